// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM port between instruction fetch and data access
//
// Purpose: grants the single RAM port to either the fetch side (i_*) or the
// data side (d_*), holds the access for LAT cycles, then pulses the granted
// side's ready strobe for one cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req, i_addr                 fetch request (held until i_rdy) and byte address
//   i_rdy, i_data                 fetch completion strobe and fetched word
//   d_req, d_we, d_addr, d_wdata  data request, store enable, byte address, store data
//   d_ubhw                        size: bit0 half, bit1 word, neither byte; bit2 unsigned
//   d_rdy, d_rdata, d_err         data completion strobe, load result, misalignment flag
//   ram_addr, ram_din, ram_we     RAM address, write data, write enable
//   ram_ubhw, ram_dout            RAM access size, RAM read data (combinational)
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rdy,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ubhw,
  output logic        d_rdy,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_ubhw,
  input  logic [31:0] ram_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_data_q, last_data_d;   // 1: data side was granted last
  logic        gnt_data_q, gnt_data_d;     // 1: current transaction belongs to data side
  logic        err_wait_q, err_wait_d;     // misaligned access spending its one idle cycle in DONE
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  ubhw_q, ubhw_d;
  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        grant_data;
  logic        misaligned;
  logic        busy;
  logic [31:0] load_val;

  // Data wins when it is the only requester, or when both request and the
  // fetch side was served last.
  assign grant_data = d_req && (!i_req || !last_data_q);

  assign misaligned = d_ubhw[1] ? (d_addr[1:0] != 2'b00) : (d_ubhw[0] && d_addr[0]);

  // RAM returns LSB-aligned data; size and signedness are applied here.
  always_comb begin
    load_val = ram_dout;
    if (!ubhw_q[1]) begin
      if (ubhw_q[0]) begin
        load_val = ubhw_q[2] ? {16'h0000, ram_dout[15:0]}
                             : {{16{ram_dout[15]}}, ram_dout[15:0]};
      end else begin
        load_val = ubhw_q[2] ? {24'h000000, ram_dout[7:0]}
                             : {{24{ram_dout[7]}}, ram_dout[7:0]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    err_wait_d  = err_wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    ubhw_d      = ubhw_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          gnt_data_d  = grant_data;
          last_data_d = grant_data;
          if (grant_data) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            ubhw_d  = d_ubhw;
          end else begin
            addr_d  = i_addr;
            wdata_d = 32'h0;
            we_d    = 1'b0;
            ubhw_d  = 3'b010;
          end
          if (grant_data && misaligned) begin
            // No RAM access at all; one idle cycle in DONE before d_rdy.
            we_d       = 1'b0;
            err_wait_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (gnt_data_q) begin
            d_err_d = 1'b0;
            if (!we_q) begin
              d_rdata_d = load_val;
            end
          end else begin
            i_data_d = ram_dout;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        if (err_wait_q) begin
          err_wait_d = 1'b0;
          d_err_d    = 1'b1;
          d_rdata_d  = 32'h0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      err_wait_q  <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      ubhw_q      <= 3'b000;
      i_data_q    <= 32'h0;
      d_rdata_q   <= 32'h0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      err_wait_q  <= err_wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      ubhw_q      <= ubhw_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  // RAM port is only driven while an access is in flight.
  assign busy     = (state_q == S_BUSY);
  assign ram_addr = busy ? addr_q  : 32'h0;
  assign ram_din  = busy ? wdata_q : 32'h0;
  assign ram_ubhw = busy ? ubhw_q  : 3'b000;
  assign ram_we   = busy && (cnt_q == 4'd0) && we_q;

  assign i_rdy   = (state_q == S_DONE) && !gnt_data_q;
  assign d_rdy   = (state_q == S_DONE) && gnt_data_q && !err_wait_q;
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_rdy;
  logic [31:0] i_data;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [2:0]  d_ubhw = 3'b000;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [2:0]  ram_ubhw;
  logic [31:0] ram_dout;

  logic        i_req4 = 1'b0;
  logic [31:0] i_addr4 = 32'h0;
  logic        i_rdy4;
  logic [31:0] i_data4;
  logic        d_req4 = 1'b0;
  logic        d_we4 = 1'b0;
  logic [31:0] d_addr4 = 32'h0;
  logic [31:0] d_wdata4 = 32'h0;
  logic [2:0]  d_ubhw4 = 3'b000;
  logic        d_rdy4;
  logic [31:0] d_rdata4;
  logic        d_err4;
  logic [31:0] ram_addr4;
  logic [31:0] ram_din4;
  logic        ram_we4;
  logic [2:0]  ram_ubhw4;
  logic [31:0] ram_dout4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ubhw(d_ubhw),
    .d_rdy(d_rdy), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_ubhw(ram_ubhw),
    .ram_dout(ram_dout)
  );

  mem_arbiter #(.LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req4), .i_addr(i_addr4), .i_rdy(i_rdy4), .i_data(i_data4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4), .d_ubhw(d_ubhw4),
    .d_rdy(d_rdy4), .d_rdata(d_rdata4), .d_err(d_err4),
    .ram_addr(ram_addr4), .ram_din(ram_din4), .ram_we(ram_we4), .ram_ubhw(ram_ubhw4),
    .ram_dout(ram_dout4)
  );

  assign ram_dout4 = 32'hCAFE0123;

  // Little-endian byte RAM; reads return raw LSB-aligned bytes, zero-filled.
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  assign ra = ram_addr[7:0];

  always_comb begin
    ram_dout = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};
    if (!ram_ubhw[1]) begin
      if (ram_ubhw[0]) ram_dout = {16'h0000, mem[8'(ra + 8'd1)], mem[ra]};
      else             ram_dout = {24'h000000, mem[ra]};
    end
  end

  always @(negedge clk) begin
    if (ram_we) begin
      mem[ra] <= ram_din[7:0];
      if (ram_ubhw[1] || ram_ubhw[0]) mem[8'(ra + 8'd1)] <= ram_din[15:8];
      if (ram_ubhw[1]) begin
        mem[8'(ra + 8'd2)] <= ram_din[23:16];
        mem[8'(ra + 8'd3)] <= ram_din[31:24];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data transaction; cyc counts edges from the sampling edge to the
  // d_rdy cycle inclusive. Ends with the DUT back in IDLE.
  task automatic run_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] ubhw, output int cyc, output int wes, output bit got);
    d_we = we; d_addr = addr; d_wdata = wdata; d_ubhw = ubhw; d_req = 1'b1;
    cyc = 0; wes = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      cyc++;
      if (ram_we) wes++;
      if (d_rdy) got = 1'b1;
    end
    d_req = 1'b0;
    tick();
  endtask

  // Both sides request together; reports which completes first and second
  // (1 = data, 0 = instruction) and whether strobes ever coincided.
  task automatic conflict(output int first, output int second, output bit ok, output bit coinc);
    int n;
    n = 0; first = -1; second = -1; coinc = 1'b0;
    i_addr = 32'h10; i_req = 1'b1;
    d_we = 1'b0; d_addr = 32'h10; d_ubhw = 3'b010; d_req = 1'b1;
    for (int k = 0; k < 30 && n < 2; k++) begin
      tick();
      if (i_rdy && d_rdy) coinc = 1'b1;
      if (d_rdy) begin
        if (n == 0) first = 1; else second = 1;
        n++; d_req = 1'b0;
      end else if (i_rdy) begin
        if (n == 0) first = 0; else second = 0;
        n++; i_req = 1'b0;
      end
    end
    ok = (n == 2);
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  initial begin
    int cyc, wes, f, s, cnt_rdy, cnt_we, cnt_d4, cnt_i4;
    bit got, ok, coinc;

    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h10] = 8'h44; mem[8'h11] = 8'h33; mem[8'h12] = 8'h22; mem[8'h13] = 8'h11;

    // Reset state
    #1;
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_ubhw", ram_ubhw, 0);
    check("rst_i_rdy", i_rdy, 0);
    check("rst_d_rdy", d_rdy, 0);
    check("rst_d_err", d_err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single fetch, LAT=2
    i_addr = 32'h10; i_req = 1'b1;
    tick();
    check("f_c1_ubhw", ram_ubhw, 3'b010);
    check("f_c1_addr", ram_addr, 32'h10);
    check("f_c1_irdy", i_rdy, 0);
    tick();
    check("f_c2_ubhw", ram_ubhw, 3'b010);
    check("f_c2_we", ram_we, 0);
    check("f_c2_irdy", i_rdy, 0);
    tick();
    check("f_c3_irdy", i_rdy, 1);
    check("f_c3_drdy", d_rdy, 0);
    check("f_c3_idata", i_data, 32'h11223344);
    i_req = 1'b0;
    tick();
    check("f_c4_irdy", i_rdy, 0);
    check("f_c4_hold", i_data, 32'h11223344);
    check("f_c4_ubhw", ram_ubhw, 0);

    // Simultaneous requests out of reset: data first
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    conflict(f, s, ok, coinc);
    check("cf1_done", ok, 1);
    check("cf1_first_data", f, 1);
    check("cf1_second_instr", s, 0);
    check("cf1_no_coinc", coinc, 0);
    check("cf1_drdata", d_rdata, 32'h11223344);
    // Data-only access makes data the last grant, so the next conflict flips
    run_xact(1'b0, 32'h10, 32'h0, 3'b010, cyc, wes, got);
    check("rr_dload_lat", cyc, 3);
    conflict(f, s, ok, coinc);
    check("cf2_done", ok, 1);
    check("cf2_first_instr", f, 0);
    check("cf2_second_data", s, 1);

    // Byte store then loads
    run_xact(1'b1, 32'h05, 32'h000000A5, 3'b000, cyc, wes, got);
    check("sb_got", got, 1);
    check("sb_lat", cyc, 3);
    check("sb_we_once", wes, 1);
    check("sb_mem", mem[8'h05], 8'hA5);
    check("sb_mem_nb", mem[8'h06], 8'h00);
    check("sb_rdata_kept", d_rdata, 32'h11223344);
    run_xact(1'b0, 32'h05, 32'h0, 3'b100, cyc, wes, got);
    check("lbu", d_rdata, 32'h000000A5);
    check("lbu_no_we", wes, 0);
    run_xact(1'b0, 32'h05, 32'h0, 3'b000, cyc, wes, got);
    check("lb", d_rdata, 32'hFFFFFFA5);
    run_xact(1'b0, 32'h04, 32'h0, 3'b001, cyc, wes, got);
    check("lh", d_rdata, 32'hFFFFA500);
    run_xact(1'b0, 32'h04, 32'h0, 3'b101, cyc, wes, got);
    check("lhu", d_rdata, 32'h0000A500);

    // Misaligned accesses
    run_xact(1'b0, 32'h06, 32'h0, 3'b010, cyc, wes, got);
    check("mis_w_got", got, 1);
    check("mis_w_lat", cyc, 2);
    check("mis_w_err", d_err, 1);
    check("mis_w_rdata", d_rdata, 32'h0);
    check("mis_w_no_we", wes, 0);
    run_xact(1'b1, 32'h03, 32'h1234, 3'b001, cyc, wes, got);
    check("mis_sh_lat", cyc, 2);
    check("mis_sh_err", d_err, 1);
    check("mis_sh_no_we", wes, 0);
    check("mis_sh_mem", mem[8'h03], 8'h00);
    run_xact(1'b0, 32'h10, 32'h0, 3'b010, cyc, wes, got);
    check("al_err_clr", d_err, 0);
    check("al_rdata", d_rdata, 32'h11223344);
    check("idata_held", i_data, 32'h11223344);

    // Reset during BUSY of a store
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_ubhw = 3'b010; d_req = 1'b1;
    tick();
    check("rb_busy_addr", ram_addr, 32'h40);
    #2; rst = 1'b1; #1;
    check("rb_ram_addr", ram_addr, 32'h0);
    check("rb_ram_din", ram_din, 32'h0);
    check("rb_ram_we", ram_we, 0);
    check("rb_d_rdata", d_rdata, 32'h0);
    check("rb_i_data", i_data, 32'h0);
    d_req = 1'b0;
    #1; rst = 1'b0;
    cnt_rdy = 0; cnt_we = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (d_rdy) cnt_rdy++;
      if (ram_we) cnt_we++;
    end
    check("rb_no_drdy", cnt_rdy, 0);
    check("rb_no_we", cnt_we, 0);
    check("rb_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);
    run_xact(1'b0, 32'h10, 32'h0, 3'b010, cyc, wes, got);
    check("rb_next_got", got, 1);
    check("rb_next_lat", cyc, 3);
    check("rb_next_data", d_rdata, 32'h11223344);

    // LAT=4, data request withdrawn after one cycle
    d_we4 = 1'b0; d_addr4 = 32'h20; d_ubhw4 = 3'b010; d_req4 = 1'b1;
    tick();
    d_req4 = 1'b0; i_addr4 = 32'h30; i_req4 = 1'b1;
    cyc = 1; got = 1'b0; coinc = 1'b0; cnt_d4 = 0; cnt_i4 = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      cyc++;
      if (d_rdy4 && i_rdy4) coinc = 1'b1;
      if (d_rdy4) begin got = 1'b1; cnt_d4++; end
    end
    check("l4_got", got, 1);
    check("l4_lat", cyc, 5);
    check("l4_rdata", d_rdata4, 32'hCAFE0123);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (d_rdy4 && i_rdy4) coinc = 1'b1;
      if (d_rdy4) cnt_d4++;
      if (i_rdy4) begin got = 1'b1; cnt_i4++; end
    end
    i_req4 = 1'b0;
    check("l4_i_got", got, 1);
    check("l4_idata", i_data4, 32'hCAFE0123);
    check("l4_no_coinc", coinc, 0);
    check("l4_one_drdy", cnt_d4, 1);
    check("l4_one_irdy", cnt_i4, 1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2, meaning: number of BUSY cycles per RAM access (legal range 1-15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch request; held until i_rdy.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdy  output  1  fetch complete strobe.
REQ-007 i_data  output  32  fetched word.
REQ-008 d_req  input  1  data request; held until d_rdy.
REQ-009 d_we  input  1  data write enable (1 = store).
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data, LSB-aligned.
REQ-012 d_ubhw  input  3  access size: bit0 half, bit1 word, neither = byte; bit2 unsigned.
REQ-013 d_rdy  output  1  data complete strobe.
REQ-014 d_rdata  output  32  load result.
REQ-015 d_err  output  1  misaligned-access flag, valid with d_rdy.
REQ-016 ram_addr  output  32  RAM byte address.
REQ-017 ram_din  output  32  RAM write data.
REQ-018 ram_we  output  1  RAM write enable (RAM samples on falling clk).
REQ-019 ram_ubhw  output  3  RAM access size, same encoding as d_ubhw.
REQ-020 ram_dout  input  32  RAM read data, combinational from ram_addr/ram_ubhw.

Function
REQ-021 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-022 IDLE: no request -> stay; any request -> latch grant, address, wdata, we, ubhw into registers, load wait counter with LAT-1, go BUSY.
REQ-023 Arbitration SHALL be round-robin: if only one requests, grant it; if both, grant the one not granted last; last-grant register updates on every grant.
REQ-024 Instruction grants SHALL drive ram_ubhw = 3'b010 and ram_we = 0.
REQ-025 Misaligned data access (half with addr[0]=1, word with addr[1:0]!=0) SHALL skip BUSY, go directly to DONE with d_err = 1, ram_we never asserted, d_rdata = 0.
REQ-026 BUSY: ram_addr/ram_din/ram_ubhw driven from latched registers for all LAT cycles; counter decrements each cycle; at counter 0 go DONE.
REQ-027 ram_we SHALL be 1 only in the final BUSY cycle of a granted, aligned store; 0 in all other cycles/states.
REQ-028 In the final BUSY cycle ram_dout SHALL be captured into the granted requester's result register (loads and fetches only; stores leave d_rdata unchanged).
REQ-029 DONE: assert i_rdy or d_rdy (granted side only) for exactly one cycle; requests not sampled; next state IDLE.
REQ-030 Latency: request sampled at edge N -> rdy high during cycle after edge N+LAT; misaligned -> rdy high after edge N+1.
REQ-031 i_data/d_rdata/d_err SHALL hold value until next completion of the same port.
REQ-032 Request withdrawn mid-transaction SHALL NOT abort; access completes, rdy still pulses.
REQ-033 i_rdy and d_rdy SHALL never be high in the same cycle.
REQ-034 Non-granted requester SHALL be served no later than the transaction immediately following the current one.

Reset
REQ-035 rst high SHALL immediately force state IDLE, counter 0, last-grant = instruction, all outputs 0 (ram_addr, ram_din, ram_ubhw, ram_we, i_rdy, d_rdy, i_data, d_rdata, d_err).
REQ-036 rst asserted mid-BUSY SHALL abandon the access: no ram_we pulse, no rdy pulse, registers cleared.

Verification
REQ-037 LAT=2, i_req only, i_addr=0x10, RAM word 0x11223344 -> ram_ubhw=010 two cycles, i_rdy one-cycle pulse after edge N+2, i_data=0x11223344.
REQ-038 Both requests simultaneously out of reset -> data granted first (d_rdy), then instruction (i_rdy) in next transaction; reversed order on next conflict.
REQ-039 Store byte d_addr=0x05, d_wdata=0xA5, d_ubhw=000 -> ram_we high exactly one cycle (final BUSY); subsequent unsigned byte load returns 0x000000A5, signed load returns 0xFFFFFFA5.
REQ-040 Word load d_addr=0x06 -> d_rdy after edge N+1, d_err=1, d_rdata=0, ram_we never high.
REQ-041 rst pulsed during BUSY of a store -> no ram_we, no d_rdy, all outputs 0, next request served normally.
REQ-042 d_req dropped after one cycle with LAT=4 -> d_rdy still pulses after edge N+4, i_rdy never coincident.
